// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the core (port 0) and the loader (port 1).
// Define DMEM_ARB_LOCK_EN to let a port hold exclusive ownership across accesses via lock_x.
module dmem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_0,
  input  logic              we_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic              lock_0,
  output logic              gnt_0,
  output logic              rvalid_0,
  output logic [DATA_W-1:0] rdata_0,
  input  logic              req_1,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  input  logic              lock_1,
  output logic              gnt_1,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rdata_1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic {ARB, ACCESS} state_t;

  state_t              state, state_nxt;
  logic                prio;
  logic                lat_we, lat_id;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic                elig_0, elig_1, pick_1, grant;

`ifdef DMEM_ARB_LOCK_EN
  logic owned, owner;

  // While owned, the non-owner is masked out before the round-robin pick.
  assign elig_0 = req_0 && !(owned && owner);
  assign elig_1 = req_1 && !(owned && !owner);
`else
  logic unused_lock;

  assign unused_lock = lock_0 | lock_1;
  assign elig_0      = req_0;
  assign elig_1      = req_1;
`endif

  assign pick_1 = elig_1 && (!elig_0 || prio);
  assign grant  = gnt_0 || gnt_1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (elig_0 || elig_1) state_nxt = ACCESS;
      ACCESS:  state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_comb begin
    gnt_0     = 1'b0;
    gnt_1     = 1'b0;
    busy      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ARB: begin
        gnt_1 = pick_1;
        gnt_0 = elig_0 && !pick_1;
      end
      ACCESS: begin
        busy      = 1'b1;
        mem_read  = !lat_we;
        mem_write = lat_we;
        mem_addr  = 32'(lat_addr);
        mem_wdata = lat_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio      <= 1'b0;
      lat_we    <= 1'b0;
      lat_id    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rvalid_0  <= 1'b0;
      rvalid_1  <= 1'b0;
      rdata_0   <= '0;
      rdata_1   <= '0;
`ifdef DMEM_ARB_LOCK_EN
      owned     <= 1'b0;
      owner     <= 1'b0;
`endif
    end else begin
      rvalid_0 <= 1'b0;
      rvalid_1 <= 1'b0;
      if (grant) begin
        lat_we    <= gnt_1 ? we_1    : we_0;
        lat_addr  <= gnt_1 ? addr_1  : addr_0;
        lat_wdata <= gnt_1 ? wdata_1 : wdata_0;
        lat_id    <= gnt_1;
        prio      <= !gnt_1;
`ifdef DMEM_ARB_LOCK_EN
        // Any grant while owned belongs to the owner, so its lock bit alone decides ownership.
        owned     <= gnt_1 ? lock_1 : lock_0;
        owner     <= gnt_1;
`endif
      end
      if (state == ACCESS && !lat_we) begin
        if (lat_id) begin
          rvalid_1 <= 1'b1;
          rdata_1  <= mem_rdata;
        end else begin
          rvalid_0 <= 1'b1;
          rdata_0  <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 512x32 RAM; unwritten words read as 0x10000000 + address.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_0, we_0, lock_0, gnt_0, rvalid_0;
  logic [8:0]  addr_0;
  logic [31:0] wdata_0, rdata_0;
  logic        req_1, we_1, lock_1, gnt_1, rvalid_1;
  logic [8:0]  addr_1;
  logic [31:0] wdata_1, rdata_1;
  logic        mem_read, mem_write, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [512];
  logic        written [512];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0), .lock_0(lock_0),
    .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
    .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1), .lock_1(lock_1),
    .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[8:0]]     <= mem_wdata;
      written[mem_addr[8:0]] <= 1'b1;
    end
  end

  assign mem_rdata = (written[mem_addr[8:0]] === 1'b1) ? mem[mem_addr[8:0]]
                                                      : 32'h1000_0000 + {23'd0, mem_addr[8:0]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req_0 = 0; we_0 = 0; addr_0 = '0; wdata_0 = '0; lock_0 = 0;
    req_1 = 0; we_1 = 0; addr_1 = '0; wdata_1 = '0; lock_1 = 0;
    next(); next();
    rst = 1'b0;
    #1;
    check("idle_gnt0", {31'd0, gnt_0}, 0);
    check("idle_gnt1", {31'd0, gnt_1}, 0);
    check("idle_rvalid", {30'd0, rvalid_1, rvalid_0}, 0);
    check("idle_strobes", {29'd0, busy, mem_read, mem_write}, 0);
    check("idle_addr", mem_addr, 0);
    check("idle_rdata0", rdata_0, 0);

    // Port 0 write then read-back of 0x005
    next();
    req_0 = 1; we_0 = 1; addr_0 = 9'h005; wdata_0 = 32'hDEADBEEF;
    #1;
    check("wr_gnt0", {30'd0, gnt_1, gnt_0}, 32'h1);
    check("wr_arb_nowrite", {31'd0, mem_write}, 0);
    next();
    req_0 = 0; we_0 = 0;
    #1;
    check("wr_access", {29'd0, busy, mem_read, mem_write}, 32'h5);
    check("wr_addr", mem_addr, 32'h0000_0005);
    check("wr_data", mem_wdata, 32'hDEADBEEF);
    check("wr_access_nognt", {30'd0, gnt_1, gnt_0}, 0);
    next();
    req_0 = 1; we_0 = 0; addr_0 = 9'h005;
    #1;
    check("wr_no_rvalid", {31'd0, rvalid_0}, 0);
    check("rd_gnt0", {30'd0, gnt_1, gnt_0}, 32'h1);
    next();
    req_0 = 0;
    #1;
    check("rd_access", {29'd0, busy, mem_read, mem_write}, 32'h6);
    check("rd_not_yet_valid", {31'd0, rvalid_0}, 0);
    next();
    #1;
    check("rd_rvalid0", {31'd0, rvalid_0}, 1);
    check("rd_rdata0", rdata_0, 32'hDEADBEEF);
    next();
    #1;
    check("rd_rvalid0_pulse", {31'd0, rvalid_0}, 0);
    check("rd_rdata0_hold", rdata_0, 32'hDEADBEEF);

    // Both ports requesting continuously from reset: alternate 0,1,0,1
    rst = 1'b1; #1; rst = 1'b0;
    next();
    req_0 = 1; we_0 = 0; addr_0 = 9'h010;
    req_1 = 1; we_1 = 0; addr_1 = 9'h020;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("rr_gnt0_c%0d", i), {31'd0, gnt_0}, {31'd0, (i % 4) == 0});
      check($sformatf("rr_gnt1_c%0d", i), {31'd0, gnt_1}, {31'd0, (i % 4) == 2});
      check($sformatf("rr_busy_c%0d", i), {31'd0, busy}, {31'd0, (i % 2) == 1});
      check($sformatf("rr_exclusive_c%0d", i), {31'd0, mem_read & mem_write}, 0);
      check($sformatf("rr_rvalid0_c%0d", i), {31'd0, rvalid_0}, {31'd0, i == 2 || i == 6});
      check($sformatf("rr_rvalid1_c%0d", i), {31'd0, rvalid_1}, {31'd0, i == 4});
      if (i == 2) check("rr_rdata0", rdata_0, 32'h1000_0010);
      if (i < 4)  check($sformatf("rr_rdata1_early_c%0d", i), rdata_1, 0);
      if (i == 4) check("rr_rdata1", rdata_1, 32'h1000_0020);
      next();
    end
    req_0 = 0; req_1 = 0;
    next(); next();

    // Port 1 read at the top word
    req_1 = 1; we_1 = 0; addr_1 = 9'h1FF;
    #1;
    check("top_gnt1", {30'd0, gnt_1, gnt_0}, 32'h2);
    next();
    req_1 = 0;
    #1;
    check("top_addr", mem_addr, 32'h0000_01FF);
    check("top_read", {30'd0, mem_read, mem_write}, 32'h2);
    next();
    #1;
    check("top_rvalid", {30'd0, rvalid_1, rvalid_0}, 32'h2);
    check("top_rdata1", rdata_1, 32'h1000_01FF);

    // Reset during the ACCESS cycle of a port 1 write
    next();
    req_1 = 1; we_1 = 1; addr_1 = 9'h030; wdata_1 = 32'h12345678;
    #1;
    check("abort_gnt1", {31'd0, gnt_1}, 1);
    next();
    req_1 = 0; we_1 = 0;
    #1;
    check("abort_write_before", {31'd0, mem_write}, 1);
    rst = 1'b1;
    #1;
    check("abort_write_drop", {31'd0, mem_write}, 0);
    check("abort_busy_drop", {31'd0, busy}, 0);
    next();
    rst = 1'b0;
    #1;
    check("abort_no_rvalid", {30'd0, rvalid_1, rvalid_0}, 0);
    req_1 = 1; addr_1 = 9'h030;
    #1;
    check("abort_arb_gnt", {31'd0, gnt_1}, 1);
    next();
    req_1 = 0;
    next();
    #1;
    check("abort_mem_unchanged", rdata_1, 32'h1000_0030);

    // Lock: port 1 read-lock then unlocking write while port 0 waits
    next();
    req_1 = 1; we_1 = 0; addr_1 = 9'h040; lock_1 = 1;
    #1;
    check("lk_c0_gnt1", {30'd0, gnt_1, gnt_0}, 32'h2);
    next();
    req_0 = 1; we_0 = 0; addr_0 = 9'h050;
    we_1 = 1; wdata_1 = 32'hCAFEF00D; lock_1 = 0;
    #1;
    check("lk_c1_nognt", {30'd0, gnt_1, gnt_0}, 0);
    next();
    #1;
    check("lk_c2_gnt", {30'd0, gnt_1, gnt_0}, {30'd0, LOCK, !LOCK});
    next();
    req_1 = !LOCK;
    #1;
    check("lk_c3_write", {31'd0, mem_write}, {31'd0, LOCK});
    next();
    #1;
    check("lk_c4_gnt", {30'd0, gnt_1, gnt_0}, {30'd0, !LOCK, LOCK});
    next();
    req_0 = 0; req_1 = 0;
    next(); next();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM (512 x 32, combinational read, write on posedge clk) between two requesters.
- Port 0 is the core load/store path. Port 1 is the program/debug loader.
- Uses round-robin arbitration, a per-port req/gnt handshake and registered read data.
- Sits between the requesters and the RAM's read, write, address and in pins.

Parameters:
- ADDR_W, 9, word-address width of requester ports (512 words).
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  asynchronous active-high reset.
- req_0  in  1  port 0 access request.
- we_0  in  1  port 0 write (1) / read (0).
- addr_0  in  ADDR_W  port 0 word address.
- wdata_0  in  DATA_W  port 0 write data.
- lock_0  in  1  port 0 lock request (used only with LOCK_EN).
- gnt_0  out  1  port 0 request accepted this cycle.
- rvalid_0  out  1  port 0 read data valid pulse.
- rdata_0  out  DATA_W  port 0 read data.
- req_1 / we_1 / addr_1 / wdata_1 / lock_1 / gnt_1 / rvalid_1 / rdata_1: same as port 0, for port 1.
- mem_read  out  1  to RAM read.
- mem_write  out  1  to RAM write.
- mem_addr  out  32  to RAM address; zero-extended from ADDR_W.
- mem_wdata  out  DATA_W  to RAM in.
- mem_rdata  in  DATA_W  from RAM out.
- busy  out  1  high while in ACCESS state.

Behaviour:
- Reset (asynchronous, active-high):
  - State = ARB; prio = 0 (port 0 favoured).
  - All gnt, rvalid, mem_read, mem_write, busy = 0; rdata_x = 0; latched request registers = 0.
- State ARB:
  - gnt_x is combinational from req_x. At most one gnt per cycle.
  - Only one req high: grant it. Both high: grant port named by prio. Neither high: stay in ARB, no mem strobes.
  - On a grant, at posedge: latch winner's we/addr/wdata and winner id; prio <= other port; go to ACCESS.
  - Requester may change or drop req the cycle after gnt.
- State ACCESS (exactly one cycle):
  - busy = 1; mem_addr = latched addr; mem_wdata = latched wdata.
  - mem_read = ~we; mem_write = we. RAM write commits at this cycle's posedge.
  - gnt_0 = gnt_1 = 0.
  - On a read, at posedge: rdata_<winner> <= mem_rdata.
  - Next state = ARB.
- rvalid_<winner>:
  - One-cycle pulse in the cycle after ACCESS, reads only.
  - rdata_x holds its value until the next read by that port.
  - The ARB cycle overlapping an rvalid pulse may grant a new request.
- Writes produce no rvalid; write completes at end of ACCESS.
- Timing:
  - Read latency: gnt in cycle N, RAM access N+1, rvalid/rdata N+2.
  - Peak throughput: one access per 2 cycles.
- Fairness: back-to-back requests from both ports alternate 0,1,0,1…; neither starves.
- Boundaries:
  - addr upper bits above ADDR_W are 0 on mem_addr.
  - mem_read and mem_write are never both 1.
  - mem_read/mem_write are 0 outside ACCESS.
- Reset asserted mid-ACCESS: access aborted, mem_write drops immediately (asynchronous), no rvalid follows. A write whose edge coincides with reset assertion is not guaranteed.

Optional Feature:
- Macro DMEM_ARB_LOCK_EN.
- Defined:
  - A grant with lock_x = 1 sets owner = x, owned = 1.
  - While owned, only the owner can be granted; the other port's req waits even if prio favours it.
  - The owner's next grant with lock_x = 0 clears owned after that access.
  - prio still toggles on each grant.
  - Reset clears owned.
  - Used for atomic read-modify-write by the loader.
- Not defined: lock_0/lock_1 ports remain but are ignored; pure round-robin.

Test Plan:
- Reset then idle → gnt, rvalid, mem_read, mem_write, busy all 0; mem_addr = 0.
- Port 0 write addr 0x005 data 0xDEADBEEF, then port 0 read 0x005 → mem_write high one cycle with mem_addr = 0x00000005; read gives rvalid_0 two cycles after gnt_0, rdata_0 = 0xDEADBEEF.
- req_0 and req_1 both held high, reads of 0x010/0x020, from reset → grant order 0,1,0,1; gnts 2 cycles apart; rdata_1 = mem[0x020] only with rvalid_1.
- Port 1 read of 0x1FF → mem_addr = 0x000001FF; rvalid_0 stays 0.
- rst pulsed in the ACCESS cycle of a port 1 write to 0x030 (new data 0x12345678) → mem_write falls same cycle; state ARB; no rvalid; mem[0x030] unchanged from its pre-access value.
- (DMEM_ARB_LOCK_EN) Port 1 reads 0x040 with lock_1 = 1 while req_0 is held; port 1 then writes 0x040 with lock_1 = 0 → port 0 granted only after port 1's unlocking write; without the macro, port 0 is granted between them.
